// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and sizing helper for the shift-add multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } mult_state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/add_nbit.sv
// add_nbit: N-bit ripple-carry adder assembled from full-adder cells
module add_nbit
    import mult_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic [N:0] c;

    assign c[0]   = cin_i;
    assign cout_o = c[N];

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned NxN multiplier, one multiplier bit per clock.
// Optional macro SHIFT_ADD_MULT_EARLY_EXIT_EN finishes as soon as no set multiplier bits remain.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic [2*N-1:0] product,
    output logic           done,
    output logic           busy
);

    localparam int CW = cnt_width(N);
    localparam logic [2*N-1:0] ONE = {{(2*N-1){1'b0}}, 1'b1};

    mult_state_t    state_q, state_d;
    logic [N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]   mreg_q, mreg_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] product_q, product_d;
    logic           done_q, done_d;

    logic [N-1:0]   win;
    logic [N-1:0]   sum;
    logic           cout;
    logic [2*N-1:0] low_mask;
    logic [2*N-1:0] add_sh;
    logic [N-1:0]   mreg_sh;
    logic           last;

    // Bits below cnt are final; everything above cnt+N-1 is still zero, so the
    // adder's carry lands in an empty bit and no wider carry chain is needed.
    assign win      = N'(acc_q >> cnt_q);
    assign low_mask = (ONE << cnt_q) - ONE;
    assign add_sh   = {{(N-1){1'b0}}, cout, sum} << cnt_q;
    assign mreg_sh  = mreg_q >> 1;
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    assign last     = (cnt_q == CW'(N-1)) || (mreg_sh == '0);
`else
    assign last     = (cnt_q == CW'(N-1));
`endif

    add_nbit #(.N(N)) u_add (
        .a_i    (win),
        .b_i    (mcand_q),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (cout)
    );

    assign product = product_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE);

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mreg_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mreg_q    <= mreg_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    // Next-state: accept in IDLE, one shift-add per CALC edge, publish in FINISH
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mreg_d    = mreg_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = multiplicand;
                    mreg_d  = multiplier;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d   = mreg_q[0] ? ((acc_q & low_mask) | add_sh) : acc_q;
                mreg_d  = mreg_sh;
                cnt_d   = cnt_q + 1'b1;
                state_d = last ? FINISH : CALC;
            end
            FINISH: begin
                product_d = acc_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed checks of latency, handshake, reset abort and products
module tb_shift_add_multiplier;

    localparam int N = 16;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [N-1:0]   a = '0;
    logic [N-1:0]   b = '0;
    logic [2*N-1:0] product;
    logic           done;
    logic           busy;

    int vectors = 0;
    int errs = 0;

    always #5 clk = ~clk;

    shift_add_multiplier #(.N(N)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .multiplicand (a),
        .multiplier   (b),
        .product      (product),
        .done         (done),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [N-1:0] bv);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
        int p;
        p = 1;
        for (int i = 0; i < N; i++) if (bv[i]) p = i + 1;
        return p + 1;
`else
        return N + 1;
`endif
    endfunction

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) return;
        end
        cyc = -1;
    endtask

    task automatic run(input logic [N-1:0] av, input logic [N-1:0] bv, input logic [2*N-1:0] pv);
        int c;
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", busy, 1);
        wait_done(c);
        check("latency", c, exp_lat(bv));
        check("product", product, pv);
        check("busy_with_done", busy, 0);
        @(posedge clk);
        #1;
        check("done_pulse_end", done, 0);
    endtask

    logic [N-1:0]   ta [8] = '{16'h0003, 16'hFFFF, 16'h1234, 16'h0001, 16'h8000, 16'h1234, 16'hAAAA, 16'h0009};
    logic [N-1:0]   tb [8] = '{16'h0005, 16'hFFFF, 16'h0000, 16'h0001, 16'h8000, 16'h5678, 16'h5555, 16'h0001};
    logic [2*N-1:0] tp [8] = '{32'h0000000F, 32'hFFFE0001, 32'h00000000, 32'h00000001,
                               32'h40000000, 32'h06260060, 32'h38E31C72, 32'h00000009};

    initial begin
        int c, c2, spurious;
        repeat (2) @(posedge clk);
        #1;
        check("reset_product", product, 0);
        check("reset_done", done, 0);
        check("reset_busy", busy, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) run(ta[i], tb[i], tp[i]);
        run(16'h0003, 16'h8000, 32'h00018000);
        run(16'h0000, 16'hFFFF, 32'h00000000);

        a = 16'd3;
        b = 16'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 16'd7;
        b = 16'd7;
        wait_done(c);
        check("held_start_latency", c, exp_lat(16'd5));
        check("held_start_product", product, 15);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", busy, 1);
        wait_done(c2);
        check("b2b_interval", c2 + 1, 1 + exp_lat(16'd7));
        check("b2b_product", product, 49);

        @(posedge clk);
        #1;
        a = 16'h00AB;
        b = 16'h0CDE;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_product", product, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        #20;
        reset_n = 1'b1;
        spurious = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) spurious++;
        end
        check("abort_no_done", spurious, 0);
        run(16'h00AB, 16'h0CDE, 32'h0008984A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
